bg_image_scaler: RTL

BG_IMAGE_SCALER -- requirements
Module: bg_image_scaler

---
 rtl/bg_image_scaler.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/bg_image_scaler.sv
`timescale 1ns/1ps
// bg_image_scaler: scales a stored IMG_W x IMG_H palette-indexed image to the
// SCREEN_W x SCREEN_H raster and applies a frame-stepped fade to black.
// Ports:
//   vga_clk, reset          pixel clock, synchronous active-high reset
//   DrawX, DrawY, blank     raster position and active-region flag (1 = active)
//   fade_in, fade_out       single-cycle fade requests (fade_out wins)
//   rom_address / rom_q     registered address to / data from a sync image ROM
//   pal_index / pal_*       palette lookup (pal_index is rom_q, combinational)
//   red, green, blue        registered, faded pixel colour (3 cycles after sample)
//   fade_busy, fade_done    fade in progress / one-cycle completion pulse
module bg_image_scaler #(
  parameter int unsigned IMG_W         = 200,
  parameter int unsigned IMG_H         = 150,
  parameter int unsigned SCREEN_W      = 640,
  parameter int unsigned SCREEN_H      = 480,
  parameter int unsigned IDX_BITS      = 3,
  parameter int unsigned ADDR_BITS     = 15,
  parameter int unsigned FADE_FRAMES   = 2,
  parameter int unsigned RESET_VISIBLE = 1
) (
  input  logic                 vga_clk,
  input  logic                 reset,
  input  logic [9:0]           DrawX,
  input  logic [9:0]           DrawY,
  input  logic                 blank,
  input  logic                 fade_in,
  input  logic                 fade_out,
  output logic [ADDR_BITS-1:0] rom_address,
  input  logic [IDX_BITS-1:0]  rom_q,
  output logic [IDX_BITS-1:0]  pal_index,
  input  logic [3:0]           pal_red,
  input  logic [3:0]           pal_green,
  input  logic [3:0]           pal_blue,
  output logic [3:0]           red,
  output logic [3:0]           green,
  output logic [3:0]           blue,
  output logic                 fade_busy,
  output logic                 fade_done
);

  localparam int unsigned ACC_W = 11;
  localparam int unsigned LVL_W = 5;
  localparam int unsigned CNT_W = $clog2(FADE_FRAMES + 1);
  localparam logic [LVL_W-1:0] LVL_MAX = 5'd16;

  typedef enum logic [1:0] {SHOWN, HIDDEN, FADING_IN, FADING_OUT} fade_state_t;

  localparam fade_state_t       RESET_STATE = (RESET_VISIBLE != 0) ? SHOWN : HIDDEN;
  localparam logic [LVL_W-1:0]  RESET_LEVEL = (RESET_VISIBLE != 0) ? LVL_MAX : 5'd0;

  logic [9:0]           x_prev, y_prev;
  logic [ACC_W-1:0]     acc_x, acc_y, acc_x_sum, acc_y_sum;
  logic [ADDR_BITS-1:0] src_x, row_base;
  logic                 x_step, y_step, frame_tick;
  logic [2:0]           blank_d;

  fade_state_t          state, state_n;
  logic [LVL_W-1:0]     level, level_n;
  logic [CNT_W-1:0]     frame_cnt, cnt_n;
  logic                 busy_n, done_n, cnt_last;

  assign pal_index  = rom_q;
  assign x_step     = (DrawX == 10'(x_prev + 10'd1));
  assign y_step     = (DrawY == 10'(y_prev + 10'd1));
  assign acc_x_sum  = acc_x + ACC_W'(IMG_W);
  assign acc_y_sum  = acc_y + ACC_W'(IMG_H);
  assign frame_tick = (DrawX == '0) && (DrawY == '0) && !((x_prev == '0) && (y_prev == '0));
  assign cnt_last   = (frame_cnt == CNT_W'(FADE_FRAMES - 1));

  // Channel scaled by fade level; level 16 passes the colour unchanged.
  function automatic logic [3:0] scale(input logic [3:0] c, input logic [LVL_W-1:0] l);
    return 4'((8'(c) * 8'(l)) >> 4);
  endfunction

  // Incremental source-coordinate tracking; row_base holds src_y*IMG_W.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      x_prev      <= '0;
      y_prev      <= '0;
      acc_x       <= '0;
      acc_y       <= '0;
      src_x       <= '0;
      row_base    <= '0;
      rom_address <= '0;
    end else begin
      x_prev      <= DrawX;
      y_prev      <= DrawY;
      rom_address <= row_base + src_x;
      if (DrawX == '0) begin
        acc_x <= '0;
        src_x <= '0;
      end else if (x_step) begin
        if (acc_x_sum >= ACC_W'(SCREEN_W)) begin
          acc_x <= acc_x_sum - ACC_W'(SCREEN_W);
          src_x <= src_x + ADDR_BITS'(1);
        end else begin
          acc_x <= acc_x_sum;
        end
      end
      if (DrawY == '0) begin
        acc_y    <= '0;
        row_base <= '0;
      end else if (y_step) begin
        if (acc_y_sum >= ACC_W'(SCREEN_H)) begin
          acc_y    <= acc_y_sum - ACC_W'(SCREEN_H);
          row_base <= row_base + ADDR_BITS'(IMG_W);
        end else begin
          acc_y <= acc_y_sum;
        end
      end
    end
  end

  // Blank delay line and output colour stage.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      blank_d <= '0;
      red     <= '0;
      green   <= '0;
      blue    <= '0;
    end else begin
      blank_d <= {blank_d[1:0], blank};
      if (blank_d[2]) begin
        red   <= scale(pal_red, level);
        green <= scale(pal_green, level);
        blue  <= scale(pal_blue, level);
      end else begin
        red   <= '0;
        green <= '0;
        blue  <= '0;
      end
    end
  end

  // Fade state register.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state     <= RESET_STATE;
      level     <= RESET_LEVEL;
      frame_cnt <= '0;
      fade_busy <= 1'b0;
      fade_done <= 1'b0;
    end else begin
      state     <= state_n;
      level     <= level_n;
      frame_cnt <= cnt_n;
      fade_busy <= busy_n;
      fade_done <= done_n;
    end
  end

  // Fade next-state: requests take priority over a coincident frame tick.
  always_comb begin
    state_n = state;
    level_n = level;
    cnt_n   = frame_cnt;
    done_n  = 1'b0;
    unique case (state)
      SHOWN: begin
        if (fade_out) begin
          state_n = FADING_OUT;
          cnt_n   = '0;
        end
      end
      HIDDEN: begin
        if (fade_in && !fade_out) begin
          state_n = FADING_IN;
          cnt_n   = '0;
        end
      end
      FADING_IN: begin
        if (fade_out) begin
          state_n = FADING_OUT;
          cnt_n   = '0;
        end else if (frame_tick) begin
          if (cnt_last) begin
            cnt_n = '0;
            if (level >= LVL_MAX - 5'd1) begin
              level_n = LVL_MAX;
              state_n = SHOWN;
              done_n  = 1'b1;
            end else begin
              level_n = level + 5'd1;
            end
          end else begin
            cnt_n = frame_cnt + CNT_W'(1);
          end
        end
      end
      FADING_OUT: begin
        if (fade_in && !fade_out) begin
          state_n = FADING_IN;
          cnt_n   = '0;
        end else if (frame_tick) begin
          if (cnt_last) begin
            cnt_n = '0;
            if (level <= 5'd1) begin
              level_n = '0;
              state_n = HIDDEN;
              done_n  = 1'b1;
            end else begin
              level_n = level - 5'd1;
            end
          end else begin
            cnt_n = frame_cnt + CNT_W'(1);
          end
        end
      end
      default: state_n = state;
    endcase
    busy_n = (state_n == FADING_IN) || (state_n == FADING_OUT);
  end

endmodule
